// File: rtl/farm_pkg.sv
// Shared definitions for the multi-zone farm controller: actuator and sensor
// slot indices, crop threshold table and the actuator state encoding.
package farm_pkg;

  // Actuator bit positions inside a zone's 4-bit act field
  localparam int PUMP   = 0;
  localparam int HEATER = 1;
  localparam int FAN    = 2;
  localparam int LAMP   = 3;
  localparam int N_ACT  = 4;

  // Sensor slot positions inside a zone's sensor field
  localparam int S_TEMP  = 0;
  localparam int S_HUM   = 1;
  localparam int S_LIGHT = 2;
  localparam int S_SOIL  = 3;

  // Nibble positions inside one profile row of the threshold table
  localparam int TH_T_LO  = 0;
  localparam int TH_T_HI  = 1;
  localparam int TH_L_LO  = 2;
  localparam int TH_L_HI  = 3;
  localparam int TH_S_LO  = 4;
  localparam int TH_S_HI  = 5;
  localparam int TH_H_ON  = 6;
  localparam int TH_H_OFF = 7;

  // One 32-bit row per crop, nibble k holds threshold k (4-bit scale).
  // Row order: [0] radish, [1] basil, [2] lettuce, [3] tomato.
  localparam logic [3:0][31:0] THR_TBL = {
    32'hAC96_A8A8,  // tomato : T 8/10 L 8/10 S 6/9  H 12/10
    32'hBDA7_8675,  // lettuce: T 5/7  L 6/8  S 7/10 H 13/11
    32'h9B96_97B9,  // basil  : T 9/11 L 7/9  S 6/9  H 11/9
    32'hAC85_7586   // radish : T 6/8  L 5/7  S 5/8  H 12/10
  };

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_FAULT = 2'd2
  } act_state_e;

  // Hysteresis request pair driving one actuator FSM
  typedef struct packed {
    logic on_req;
    logic off_req;
  } act_req_t;

  function automatic logic [3:0] thr_nib(input logic [1:0] prof, input int idx);
    logic [31:0] row;
    row = THR_TBL[prof];
    return row[idx*4 +: 4];
  endfunction

endpackage

// File: rtl/farm_actuator_fsm.sv
// One hysteresis actuator: OFF/ON/FAULT state, minimum dwell between
// transitions, override kill and an optional on-time watchdog (pump only).
module farm_actuator_fsm
  import farm_pkg::*;
#(
  parameter int MIN_DWELL   = 16,
  parameter int PUMP_MAX_ON = 1024,
  parameter bit WDOG_EN     = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     ena,
  input  logic     override,
  input  logic     fault_clr,
  input  act_req_t req,
  output logic     act,
  output logic     fault
);

  localparam int DW_W = $clog2(MIN_DWELL + 1);
  localparam int OT_W = $clog2(PUMP_MAX_ON + 1);
  localparam logic [DW_W-1:0] DWELL_LD = DW_W'(MIN_DWELL);
  localparam logic [OT_W-1:0] OT_MAX   = OT_W'(PUMP_MAX_ON);

  act_state_e      state_q, state_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [OT_W-1:0] ontime_q, ontime_d;
  logic            act_q, act_d;
  logic            fault_q, fault_d;
  logic            dwell_done;

  // The counter reaching zero on this very edge counts as expired, so two
  // transitions land exactly MIN_DWELL edges apart.
  assign dwell_done = (dwell_q <= DW_W'(1));

  // Next-state, dwell and on-time computation
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    ontime_d = ontime_q;
    if (dwell_q != '0) dwell_d = dwell_q - 1'b1;
    if (override) begin
      // Kill ON immediately; FAULT survives (fault_clr waits for release)
      dwell_d  = '0;
      ontime_d = '0;
      if (state_q == ST_ON) state_d = ST_OFF;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (req.on_req && dwell_done) begin
            state_d  = ST_ON;
            dwell_d  = DWELL_LD;
            ontime_d = '0;
          end
        end
        ST_ON: begin
          if (WDOG_EN) ontime_d = ontime_q + 1'b1;
          // Timeout beats the dwell gate and any off request
          if (WDOG_EN && (ontime_d == OT_MAX)) begin
            state_d  = ST_FAULT;
            dwell_d  = DWELL_LD;
            ontime_d = '0;
          end else if (req.off_req && dwell_done) begin
            state_d  = ST_OFF;
            dwell_d  = DWELL_LD;
            ontime_d = '0;
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            state_d = ST_OFF;
            dwell_d = DWELL_LD;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
    act_d   = (state_d == ST_ON);
    fault_d = (state_d == ST_FAULT);
  end

  // State and registered outputs; ena low freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_OFF;
      dwell_q  <= '0;
      ontime_q <= '0;
      act_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      ontime_q <= ontime_d;
      act_q    <= act_d;
      fault_q  <= fault_d;
    end
  end

  assign act   = act_q;
  assign fault = fault_q;

endmodule

// File: rtl/farm_zone_ctrl.sv
// Multi-zone actuator controller: registers sensor/profile samples, derives
// per-actuator hysteresis requests from the crop table and runs one FSM per
// actuator per zone.
module farm_zone_ctrl
  import farm_pkg::*;
#(
  parameter int N_ZONES     = 2,
  parameter int SENSOR_W    = 4,
  parameter int MIN_DWELL   = 16,
  parameter int PUMP_MAX_ON = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ena,
  input  logic                            override,
  input  logic                            sample_valid,
  input  logic [N_ZONES*4*SENSOR_W-1:0]   sensors,
  input  logic [N_ZONES*2-1:0]            profile,
  input  logic                            fault_clr,
  output logic [N_ZONES*4-1:0]            act,
  output logic [N_ZONES-1:0]              fault
);

  logic [N_ZONES-1:0][3:0][SENSOR_W-1:0] smp_q, smp_d;
  logic [N_ZONES-1:0][1:0]               prof_q, prof_d;

  // 4-bit table threshold placed in the top nibble of a SENSOR_W reading
  function automatic logic [SENSOR_W-1:0] scale(input logic [3:0] t);
    return SENSOR_W'(t) << (SENSOR_W - 4);
  endfunction

  // Sample capture select
  always_comb begin
    smp_d  = smp_q;
    prof_d = prof_q;
    if (sample_valid && ena) begin
      smp_d  = sensors;
      prof_d = profile;
    end
  end

  // Sample registers; decisions only ever see this copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q  <= '0;
      prof_q <= '0;
    end else begin
      smp_q  <= smp_d;
      prof_q <= prof_d;
    end
  end

  for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
    logic [SENSOR_W-1:0]  temp, hum, light, soil;
    logic [1:0]           p;
    act_req_t [N_ACT-1:0] req;

    assign temp  = smp_q[z][S_TEMP];
    assign hum   = smp_q[z][S_HUM];
    assign light = smp_q[z][S_LIGHT];
    assign soil  = smp_q[z][S_SOIL];
    assign p     = prof_q[z];

    // Hysteresis requests; between thresholds neither is raised
    always_comb begin
      req                 = '0;
      req[HEATER].on_req  = temp  <  scale(thr_nib(p, TH_T_LO));
      req[HEATER].off_req = temp  >= scale(thr_nib(p, TH_T_HI));
      req[LAMP].on_req    = light <  scale(thr_nib(p, TH_L_LO));
      req[LAMP].off_req   = light >= scale(thr_nib(p, TH_L_HI));
      req[PUMP].on_req    = soil  <  scale(thr_nib(p, TH_S_LO));
      req[PUMP].off_req   = soil  >= scale(thr_nib(p, TH_S_HI));
      req[FAN].on_req     = hum   >= scale(thr_nib(p, TH_H_ON));
      req[FAN].off_req    = hum   <  scale(thr_nib(p, TH_H_OFF));
    end

    for (genvar a = 0; a < N_ACT; a++) begin : g_act
      if (a == PUMP) begin : g_pump
        farm_actuator_fsm #(
          .MIN_DWELL  (MIN_DWELL),
          .PUMP_MAX_ON(PUMP_MAX_ON),
          .WDOG_EN    (1'b1)
        ) u_fsm (
          .clk      (clk),
          .rst_n    (rst_n),
          .ena      (ena),
          .override (override),
          .fault_clr(fault_clr),
          .req      (req[a]),
          .act      (act[z*4+a]),
          .fault    (fault[z])
        );
      end else begin : g_aux
        logic fault_unused;
        farm_actuator_fsm #(
          .MIN_DWELL  (MIN_DWELL),
          .PUMP_MAX_ON(PUMP_MAX_ON),
          .WDOG_EN    (1'b0)
        ) u_fsm (
          .clk      (clk),
          .rst_n    (rst_n),
          .ena      (ena),
          .override (override),
          .fault_clr(fault_clr),
          .req      (req[a]),
          .act      (act[z*4+a]),
          .fault    (fault_unused)
        );
      end
    end
  end

endmodule

// File: tb/tb_farm_zone_ctrl.sv
// Directed bench for farm_zone_ctrl: two radish/basil zones, 4-bit sensors,
// MIN_DWELL=16, PUMP_MAX_ON=32.
module tb_farm_zone_ctrl;
  localparam int NZ = 2;
  localparam int SW = 4;

  logic              clk = 1'b0;
  logic              rst_n, ena, override, sample_valid, fault_clr;
  logic [NZ*4*SW-1:0] sensors;
  logic [NZ*2-1:0]   profile;
  logic [NZ*4-1:0]   act;
  logic [NZ-1:0]     fault;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] zs [NZ][4];
  logic [1:0] zp [NZ];

  always #5 clk = ~clk;

  farm_zone_ctrl #(
    .N_ZONES(NZ), .SENSOR_W(SW), .MIN_DWELL(16), .PUMP_MAX_ON(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .override(override),
    .sample_valid(sample_valid), .sensors(sensors), .profile(profile),
    .fault_clr(fault_clr), .act(act), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_zone(input int z, input logic [3:0] t, input logic [3:0] h,
                          input logic [3:0] l, input logic [3:0] s, input logic [1:0] p);
    zs[z][0] = t; zs[z][1] = h; zs[z][2] = l; zs[z][3] = s; zp[z] = p;
  endtask

  task automatic pack_inputs();
    for (int z = 0; z < NZ; z++) begin
      for (int k = 0; k < 4; k++) sensors[(z*4+k)*SW +: SW] = zs[z][k];
      profile[z*2 +: 2] = zp[z];
    end
  endtask

  // One-edge capture strobe; returns at the negedge after the capture edge
  task automatic drive_sample();
    pack_inputs();
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; override = 1'b0; sample_valid = 1'b0; fault_clr = 1'b0;
    set_zone(0, 7, 11, 6, 6, 0);
    set_zone(1, 7, 11, 6, 6, 0);
    pack_inputs();
    tick(2);
    chk("rst_act", act, 0);
    chk("rst_fault", fault, 0);

    // Heater hysteresis; override keeps the zeroed sample regs from acting
    rst_n = 1'b1; override = 1'b1;
    set_zone(0, 5, 11, 6, 6, 0);
    drive_sample();
    override = 1'b0;
    chk("heat_pre", act, 8'h00);
    tick();
    chk("heat_on", act, 8'h02);
    set_zone(0, 7, 11, 6, 6, 0);
    drive_sample();
    chk("heat_hold", act, 8'h02);
    set_zone(0, 8, 11, 6, 6, 0);
    drive_sample();
    tick(13);
    chk("heat_dwell", act, 8'h02);
    tick();
    chk("heat_off", act, 8'h00);

    // Dwell: pump on, off request next cycle, off 16 edges after on
    set_zone(0, 7, 11, 6, 3, 0);
    drive_sample();
    set_zone(0, 7, 11, 6, 9, 0);
    drive_sample();
    chk("pump_on", act, 8'h01);
    tick(15);
    chk("pump_dwell", act, 8'h01);
    tick();
    chk("pump_off", act, 8'h00);

    // Watchdog: soil 0, pump re-enters ON after its dwell, trips at 32
    set_zone(0, 7, 11, 6, 0, 0);
    drive_sample();
    tick(14);
    chk("wd_wait", act, 8'h00);
    tick();
    chk("wd_on", act, 8'h01);
    tick(31);
    chk("wd_pre_act", act, 8'h01);
    chk("wd_pre_fault", fault, 2'b00);
    fault_clr = 1'b1;              // same edge as timeout: timeout wins
    tick();
    fault_clr = 1'b0;
    chk("wd_trip_act", act, 8'h00);
    chk("wd_trip_fault", fault, 2'b01);
    tick(2);
    chk("wd_latched", fault, 2'b01);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_fault", fault, 2'b00);
    chk("clr_act", act, 8'h00);
    tick(15);
    chk("reon_wait", act, 8'h00);
    tick();
    chk("reon", act, 8'h01);

    // Override: everything on in both zones, then kill and release
    set_zone(0, 0, 15, 0, 0, 0);
    set_zone(1, 0, 15, 0, 0, 0);
    drive_sample();
    tick();
    chk("ovr_allon", act, 8'hFF);
    override = 1'b1;
    tick();
    chk("ovr_off", act, 8'h00);
    tick(3);
    chk("ovr_hold", act, 8'h00);
    override = 1'b0;
    tick();
    chk("ovr_rel", act, 8'hFF);

    // Zone independence: basil temp 9 holds, radish temp 9 turns off
    set_zone(0, 9, 10, 8, 9, 1);
    set_zone(1, 9, 11, 6, 0, 0);
    drive_sample();
    tick(15);
    chk("zi_act", act, 8'hDE);
    chk("zi_fault", fault, 2'b00);
    tick(15);
    chk("zi_pre_fault", fault, 2'b00);
    tick();
    chk("z1_fault_act", act, 8'hCE);
    chk("z1_fault", fault, 2'b10);
    override = 1'b1;
    tick();
    chk("ovr_fault_act", act, 8'h00);
    chk("ovr_fault_keep", fault, 2'b10);

    // Reset mid-run: zone0 pump on, zone1 fault latched
    override = 1'b0;
    set_zone(0, 9, 10, 8, 0, 1);
    drive_sample();
    tick();
    chk("pre_rst_act", act, 8'h01);
    chk("pre_rst_fault", fault, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_act", act, 8'h00);
    chk("rst_async_fault", fault, 2'b00);
    tick();
    rst_n = 1'b1;

    // ena low: no capture and no transitions even with live requests
    ena = 1'b0;
    set_zone(0, 7, 11, 6, 6, 0);
    set_zone(1, 7, 11, 6, 6, 0);
    pack_inputs();
    sample_valid = 1'b1;
    tick(3);
    chk("ena_freeze", act, 8'h00);
    sample_valid = 1'b0;
    ena = 1'b1;
    tick();
    chk("ena_resume", act, 8'hBB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
